gpio_csr_bank: RTL and testbench

- Parametrised CSR-mapped GPIO unit that sits beside the core's execute/writeback stages. It replaces hard-wired two-in/two-out IO handling.
- Provides N_IN synchronised input channels, N_OUT output channels with CSR read/set/clear semantics, and a sticky per-input change-flag register.
- Read data is registered and returns one cycle after the request, aligned with writeback.
- With default parameters the address map is F00/F01 (inputs) and F02/F03 (outputs).

---
 rtl/gpio_csr_pkg.sv | 46 ++++
 rtl/gpio_sync.sv | 30 +++
 rtl/gpio_csr_bank.sv | 131 +++++++++++++
 tb/tb_gpio_csr_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_csr_pkg.sv
// Shared types and CSR address decode for the GPIO CSR bank.
package gpio_csr_pkg;

  typedef enum logic [1:0] {
    OP_READ = 2'd0,
    OP_RW   = 2'd1,
    OP_RS   = 2'd2,
    OP_RC   = 2'd3
  } csr_op_e;

  localparam logic [11:0] GPIO_BASE_ADDR = 12'hF00;
  localparam logic [11:0] GPIO_CHG_ADDR  = 12'hFC0;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_IN,
    SEL_OUT,
    SEL_CHG
  } csr_sel_e;

  typedef struct packed {
    csr_sel_e   kind;
    logic [3:0] idx;
  } csr_sel_t;

  // Maps a CSR address to an input channel, output channel, the change-flag register or nothing.
  function automatic csr_sel_t csr_decode(input logic [11:0] addr, input logic [11:0] base,
                                          input logic [11:0] chg, input int n_in, input int n_out);
    csr_sel_t sel;
    int       off;
    sel.kind = SEL_NONE;
    sel.idx  = '0;
    off = int'({20'd0, addr}) - int'({20'd0, base});
    if (addr == chg) begin
      sel.kind = SEL_CHG;
    end else if (off >= 0 && off < n_in) begin
      sel.kind = SEL_IN;
      sel.idx  = 4'(off);
    end else if (off >= n_in && off < n_in + n_out) begin
      sel.kind = SEL_OUT;
      sel.idx  = 4'(off - n_in);
    end
    return sel;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// W-bit multi-stage input synchroniser with a previous-value register and change detect.
module gpio_sync #(
  parameter int W      = 32,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         changed
);

  logic [W-1:0] stg [STAGES];
  logic [W-1:0] prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) stg[k] <= '0;
      prev <= '0;
    end else begin
      stg[0] <= d;
      for (int k = 1; k < STAGES; k++) stg[k] <= stg[k-1];
      prev <= stg[STAGES-1];
    end
  end

  assign q       = stg[STAGES-1];
  assign changed = |(q ^ prev);

endmodule

// File: rtl/gpio_csr_bank.sv
// CSR-mapped GPIO bank: synchronised inputs, set/clear-able outputs and sticky change flags.
module gpio_csr_bank
  import gpio_csr_pkg::*;
#(
  parameter int          N_IN        = 2,
  parameter int          N_OUT       = 2,
  parameter int          W           = 32,
  parameter logic [11:0] BASE_ADDR   = GPIO_BASE_ADDR,
  parameter logic [11:0] CHG_ADDR    = GPIO_CHG_ADDR,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_IN*W-1:0]    io_in,
  output logic [N_OUT*W-1:0]   io_out,
  input  logic                 req_valid,
  input  logic [11:0]          req_addr,
  input  logic [1:0]           req_op,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic                 rsp_hit,
  output logic [31:0]          rsp_rdata
);

  localparam int BASE_I = int'({20'd0, BASE_ADDR});
  localparam int CHG_I  = int'({20'd0, CHG_ADDR});

  if (N_IN < 1 || N_IN > 16 || N_OUT < 1 || N_OUT > 16 || W < 1 || W > 32 || SYNC_STAGES < 1)
  begin : g_bad_param
    $error("gpio_csr_bank: parameter out of range");
  end

  // Channel window must end at or before CHG_ADDR; this also rejects any overlap.
  if (BASE_I + N_IN + N_OUT > CHG_I) begin : g_bad_map
    $error("gpio_csr_bank: channel window overlaps or passes CHG_ADDR");
  end

  logic [W-1:0]    sync_v [N_IN];
  logic [N_IN-1:0] chg_now;
  logic [N_IN-1:0] flags;
  logic [W-1:0]    out_q  [N_OUT];

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    gpio_sync #(.W(W), .STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .d       (io_in[i*W +: W]),
      .q       (sync_v[i]),
      .changed (chg_now[i])
    );
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    assign io_out[j*W +: W] = out_q[j];
  end

  csr_sel_t     sel;
  csr_op_e      op;
  logic [W-1:0] wmask;
  logic [W-1:0] out_old;
  logic [W-1:0] out_new;
  logic [31:0]  rd_data;
  logic         hit;
  logic         out_wr;
  logic         chg_clr;

  assign sel     = csr_decode(req_addr, BASE_ADDR, CHG_ADDR, N_IN, N_OUT);
  assign op      = csr_op_e'(req_op);
  assign wmask   = req_wdata[W-1:0];
  assign out_wr  = req_valid && sel.kind == SEL_OUT && op != OP_READ;
  assign chg_clr = req_valid && sel.kind == SEL_CHG;

  always_comb begin
    rd_data = '0;
    hit     = 1'b0;
    out_old = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (sel.idx == 4'(j)) out_old = out_q[j];
    end
    case (sel.kind)
      SEL_IN: begin
        hit = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
          if (sel.idx == 4'(i)) rd_data = 32'(sync_v[i]);
        end
      end
      SEL_OUT: begin
        hit     = 1'b1;
        rd_data = 32'(out_old);
      end
      SEL_CHG: begin
        hit     = 1'b1;
        rd_data = 32'(flags);
      end
      default: ;
    endcase
  end

  always_comb begin
    out_new = out_old;
    case (op)
      OP_RW:   out_new = wmask;
      OP_RS:   out_new = out_old | wmask;
      OP_RC:   out_new = out_old & ~wmask;
      default: out_new = out_old;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < N_OUT; j++) out_q[j] <= OUT_RESET[W-1:0];
      flags     <= '0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (out_wr && sel.idx == 4'(j)) out_q[j] <= out_new;
      end
      // A change seen in the clearing cycle survives the clear.
      flags     <= (chg_clr ? '0 : flags) | chg_now;
      rsp_valid <= req_valid;
      if (req_valid) begin
        rsp_hit   <= hit;
        rsp_rdata <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_gpio_csr_bank.sv
// Bench for gpio_csr_bank: default map with non-zero output reset, plus a narrow 4-in/3-out build.
module tb_gpio_csr_bank;
  import gpio_csr_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] io_in_a, io_out_a;
  logic        req_valid_a, rsp_valid_a, rsp_hit_a;
  logic [11:0] req_addr_a;
  logic [1:0]  req_op_a;
  logic [31:0] req_wdata_a, rsp_rdata_a;

  logic [31:0] io_in_b;
  logic [23:0] io_out_b;
  logic        req_valid_b, rsp_valid_b, rsp_hit_b;
  logic [11:0] req_addr_b;
  logic [1:0]  req_op_b;
  logic [31:0] req_wdata_b, rsp_rdata_b;

  gpio_csr_bank #(.OUT_RESET(32'h0000_00A5)) dut_a (
    .clk(clk), .rst_n(rst_n), .io_in(io_in_a), .io_out(io_out_a),
    .req_valid(req_valid_a), .req_addr(req_addr_a), .req_op(req_op_a), .req_wdata(req_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_hit(rsp_hit_a), .rsp_rdata(rsp_rdata_a)
  );

  gpio_csr_bank #(.N_IN(4), .N_OUT(3), .W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .io_in(io_in_b), .io_out(io_out_b),
    .req_valid(req_valid_b), .req_addr(req_addr_b), .req_op(req_op_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_hit(rsp_hit_b), .rsp_rdata(rsp_rdata_b)
  );

  typedef struct {
    logic        hit;
    logic [31:0] rdata;
    int          due;
    string       name;
  } exp_t;

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] rdata;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  vec_t va[13];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic req(input bit to_b, input logic [11:0] addr, input logic [1:0] op,
                     input logic [31:0] wdata, input logic hit, input logic [31:0] rdata,
                     input string name);
    exp_t e;
    e.hit = hit;
    e.rdata = rdata;
    e.due = cyc + 1;
    e.name = name;
    if (!to_b) begin
      req_valid_a = 1'b1; req_addr_a = addr; req_op_a = op; req_wdata_a = wdata;
      qa.push_back(e);
    end else begin
      req_valid_b = 1'b1; req_addr_b = addr; req_op_b = op; req_wdata_b = wdata;
      qb.push_back(e);
    end
    @(negedge clk);
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Response scoreboards: each expected entry must appear exactly on its due cycle.
  always @(negedge clk) begin
    if (rsp_valid_a) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_rsp: got=valid want=no response");
      end else begin
        ea = qa.pop_front();
        chk({ea.name, "_cycle"}, 64'(cyc), 64'(ea.due));
        chk({ea.name, "_hit"}, 64'(rsp_hit_a), 64'(ea.hit));
        chk({ea.name, "_rdata"}, 64'(rsp_rdata_a), 64'(ea.rdata));
      end
    end else if (qa.size() != 0 && qa[0].due <= cyc) begin
      ea = qa.pop_front();
      total++; bad++;
      $display("FAIL %s_missing: got=no response want=response at cycle %0d", ea.name, ea.due);
    end
  end

  always @(negedge clk) begin
    if (rsp_valid_b) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_rsp: got=valid want=no response");
      end else begin
        eb = qb.pop_front();
        chk({eb.name, "_cycle"}, 64'(cyc), 64'(eb.due));
        chk({eb.name, "_hit"}, 64'(rsp_hit_b), 64'(eb.hit));
        chk({eb.name, "_rdata"}, 64'(rsp_rdata_b), 64'(eb.rdata));
      end
    end else if (qb.size() != 0 && qb[0].due <= cyc) begin
      eb = qb.pop_front();
      total++; bad++;
      $display("FAIL %s_missing: got=no response want=response at cycle %0d", eb.name, eb.due);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    io_in_a = '0; req_valid_a = 1'b0; req_addr_a = '0; req_op_a = '0; req_wdata_a = '0;
    io_in_b = '0; req_valid_b = 1'b0; req_addr_b = '0; req_op_b = '0; req_wdata_b = '0;

    va[0]  = '{12'hF02, OP_READ, 32'h0,         1'b1, 32'h0000_00A5};
    va[1]  = '{12'hF03, OP_RW,   32'h0,         1'b1, 32'h0000_00A5};
    va[2]  = '{12'hF03, OP_RW,   32'hF0F0_0000, 1'b1, 32'h0000_0000};
    va[3]  = '{12'hF03, OP_RS,   32'h0000_000F, 1'b1, 32'hF0F0_0000};
    va[4]  = '{12'hF03, OP_RC,   32'hF000_0000, 1'b1, 32'hF0F0_000F};
    va[5]  = '{12'hF03, OP_READ, 32'h0,         1'b1, 32'h00F0_000F};
    va[6]  = '{12'h123, OP_RW,   32'hFFFF_FFFF, 1'b0, 32'h0};
    va[7]  = '{12'hF00, OP_RW,   32'hFFFF_FFFF, 1'b1, 32'h0};
    va[8]  = '{12'hFC0, OP_RS,   32'hFFFF_FFFF, 1'b1, 32'h0};
    va[9]  = '{12'hF02, OP_RC,   32'h0000_0005, 1'b1, 32'h0000_00A5};
    va[10] = '{12'hF02, OP_READ, 32'h0,         1'b1, 32'h0000_00A0};
    va[11] = '{12'hF04, OP_RW,   32'hFFFF_FFFF, 1'b0, 32'h0};
    va[12] = '{12'hFBF, OP_READ, 32'h0,         1'b0, 32'h0};

    idle(3);
    chk("rst_io_out_a", io_out_a, {32'h0000_00A5, 32'h0000_00A5});
    chk("rst_rsp_valid_a", 64'(rsp_valid_a), 64'h0);
    chk("rst_rsp_hit_a", 64'(rsp_hit_a), 64'h0);
    chk("rst_rsp_rdata_a", 64'(rsp_rdata_a), 64'h0);
    chk("rst_io_out_b", 64'(io_out_b), 64'h0);
    rst_n = 1'b1;

    for (int v = 0; v < 13; v++) begin
      req(1'b0, va[v].addr, va[v].op, va[v].wdata, va[v].hit, va[v].rdata, $sformatf("vec%0d", v));
    end
    chk("table_io_out_a", io_out_a, {32'h00F0_000F, 32'h0000_00A0});

    // Idle cycle keeps the last response data but drops rsp_valid.
    req(1'b0, 12'hF03, OP_READ, 32'h0, 1'b1, 32'h00F0_000F, "hold_rd");
    idle(1);
    chk("hold_valid", 64'(rsp_valid_a), 64'h0);
    chk("hold_hit", 64'(rsp_hit_a), 64'h1);
    chk("hold_rdata", 64'(rsp_rdata_a), 64'h00F0_000F);

    io_in_a[63:32] = 32'h1234_5678;
    idle(3);
    req(1'b0, 12'hF01, OP_READ, 32'h0, 1'b1, 32'h1234_5678, "in1_rd");
    req(1'b0, 12'hFC0, OP_READ, 32'h0, 1'b1, 32'h0000_0002, "chg_in1");
    req(1'b0, 12'hFC0, OP_READ, 32'h0, 1'b1, 32'h0000_0000, "chg_cleared");

    // Change on ch0 arrives in the very cycle of the clearing read: the set must win.
    io_in_a[31:0] = 32'h1;
    idle(2);
    req(1'b0, 12'hFC0, OP_READ, 32'h0, 1'b1, 32'h0000_0000, "chg_race");
    req(1'b0, 12'hFC0, OP_READ, 32'h0, 1'b1, 32'h0000_0001, "chg_race_kept");
    req(1'b0, 12'hFC0, OP_READ, 32'h0, 1'b1, 32'h0000_0000, "chg_race_clr");

    // Reset arriving with a write in flight: no response and no write.
    req_valid_a = 1'b1; req_addr_a = 12'hF03; req_op_a = OP_RW; req_wdata_a = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    @(negedge clk);
    req_valid_a = 1'b0;
    chk("rst_mid_valid", 64'(rsp_valid_a), 64'h0);
    chk("rst_mid_io_out", io_out_a, {32'h0000_00A5, 32'h0000_00A5});
    rst_n = 1'b1;

    req(1'b1, 12'hF05, OP_RW, 32'h0000_01FF, 1'b1, 32'h0, "b_wr_f05");
    chk("b_io_out_ch1", 64'(io_out_b[15:8]), 64'hFF);
    req(1'b1, 12'hF05, OP_READ, 32'h0, 1'b1, 32'h0000_00FF, "b_rd_f05");
    req(1'b1, 12'hF06, OP_RS, 32'h0000_0003, 1'b1, 32'h0, "b_rs_f06");
    req(1'b1, 12'hF06, OP_READ, 32'h0, 1'b1, 32'h0000_0003, "b_rd_f06");
    req(1'b1, 12'hF07, OP_RW, 32'h0000_00FF, 1'b0, 32'h0, "b_unmapped_f07");
    req(1'b1, 12'hF04, OP_RC, 32'h0000_00FF, 1'b1, 32'h0, "b_rc_f04");
    io_in_b[31:24] = 8'h5A;
    idle(3);
    req(1'b1, 12'hF03, OP_READ, 32'h0, 1'b1, 32'h0000_005A, "b_in3_rd");
    req(1'b1, 12'hFC0, OP_READ, 32'h0, 1'b1, 32'h0000_0008, "b_chg");
    chk("b_io_out_final", 64'(io_out_b), 64'h03_FF_00);

    idle(3);
    chk("a_queue_drained", 64'(qa.size()), 64'h0);
    chk("b_queue_drained", 64'(qb.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
